result_ram_writer: RTL and testbench

Writer-side counterpart of the operand ROM reader. The ROM reader fetches 8-bit operand bytes by 9-bit address. This block takes each finished ALU result, a 16-bit value plus a 16-bit remainder, and stores it as a 4-byte record into an external byte-wide result RAM, using sequential 9-bit addresses. It sits between the result register / remainder register outputs and the result RAM write port.

---
 rtl/result_ram_writer_pkg.sv | 45 ++++
 rtl/result_ram_writer_wr_byte_mux.sv | 22 ++
 rtl/result_ram_writer.sv | 103 ++++++++++
 tb/tb_result_ram_writer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_ram_writer_pkg.sv
// Shared constants, FSM encoding and record layout for the result RAM writer.
// The operand ROM reader uses the same ADDR_W/DATA_W so both sides address the same byte space.
package result_ram_writer_pkg;

  localparam int DATA_W       = 8;
  localparam int ADDR_W       = 9;
  localparam int RES_W        = 16;
  localparam int CNT_W        = 8;
  localparam int RECORD_BYTES = 4;
  localparam int LANE_W       = $clog2(RECORD_BYTES);

  // Byte lanes in write order: the record is little-endian, value first.
  localparam logic [LANE_W-1:0] LANE_VAL_LO  = 2'd0;
  localparam logic [LANE_W-1:0] LANE_VAL_HI  = 2'd1;
  localparam logic [LANE_W-1:0] LANE_REST_LO = 2'd2;
  localparam logic [LANE_W-1:0] LANE_REST_HI = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WB0  = 3'd1,
    ST_WB1  = 3'd2,
    ST_WB2  = 3'd3,
    ST_WB3  = 3'd4,
    ST_FULL = 3'd5
  } state_t;

  typedef struct packed {
    logic [RES_W-1:0] rest;
    logic [RES_W-1:0] value;
  } rec_t;

  function automatic logic is_write(state_t s);
    return (s == ST_WB0) || (s == ST_WB1) || (s == ST_WB2) || (s == ST_WB3);
  endfunction

  function automatic logic [LANE_W-1:0] state_lane(state_t s);
    case (s)
      ST_WB1:  return LANE_VAL_HI;
      ST_WB2:  return LANE_REST_LO;
      ST_WB3:  return LANE_REST_HI;
      default: return LANE_VAL_LO;
    endcase
  endfunction

endpackage

// File: rtl/result_ram_writer_wr_byte_mux.sv
// Picks one byte of the captured result record by byte lane.
// Purely combinational, zero latency, no backpressure.
module result_ram_writer_wr_byte_mux
  import result_ram_writer_pkg::*;
(
  input  rec_t              rec,
  input  logic [LANE_W-1:0] lane,
  output logic [DATA_W-1:0] lane_byte
);

  always_comb begin
    lane_byte = rec.value[DATA_W-1:0];
    case (lane)
      LANE_VAL_LO:  lane_byte = rec.value[DATA_W-1:0];
      LANE_VAL_HI:  lane_byte = rec.value[2*DATA_W-1:DATA_W];
      LANE_REST_LO: lane_byte = rec.rest[DATA_W-1:0];
      LANE_REST_HI: lane_byte = rec.rest[2*DATA_W-1:DATA_W];
      default:      lane_byte = rec.value[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/result_ram_writer.sv
// Stores each accepted result/remainder pair as a 4-byte little-endian record at sequential RAM addresses.
// Writes occupy the 4 cycles after the transfer; res_ready drops while writing and stays low once the RAM is full.
module result_ram_writer
  import result_ram_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [RES_W-1:0]  res_value,
  input  logic [RES_W-1:0]  res_rest,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  rec_count,
  output logic              full,
  output logic              busy
);

  state_t            state, state_nxt;
  rec_t              cap;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] data_hold;
  logic [DATA_W-1:0] lane_byte;
  logic              in_wr;
  logic              ptr_last;
  logic              xfer;

  assign in_wr    = is_write(state);
  assign ptr_last = (ptr == {ADDR_W{1'b1}});
  assign xfer     = res_valid && res_ready;

  result_ram_writer_wr_byte_mux u_mux (
    .rec       (cap),
    .lane      (state_lane(state)),
    .lane_byte (lane_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (res_valid) state_nxt = ST_WB0;
        ST_WB0:  state_nxt = ST_WB1;
        ST_WB1:  state_nxt = ST_WB2;
        ST_WB2:  state_nxt = ST_WB3;
        // Last byte of the final slot wraps the pointer: stop rather than overwrite record 0.
        ST_WB3:  state_nxt = ptr_last ? ST_FULL : ST_IDLE;
        ST_FULL: state_nxt = ST_FULL;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    res_ready = (state == ST_IDLE) && !clear;
    wr_en     = in_wr && !clear;
    busy      = in_wr;
    full      = (state == ST_FULL);
    wr_addr   = wr_en ? ptr       : addr_hold;
    wr_data   = wr_en ? lane_byte : data_hold;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      rec_count <= '0;
      cap       <= '0;
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      if (clear) begin
        ptr       <= '0;
        rec_count <= '0;
      end else if (in_wr) begin
        ptr <= ptr + ADDR_W'(1);
        if (state == ST_WB3) rec_count <= rec_count + CNT_W'(1);
      end
      if (xfer) begin
        cap.value <= res_value;
        cap.rest  <= res_rest;
      end
      // Idle outputs replay the last byte actually written.
      if (wr_en) begin
        addr_hold <= ptr;
        data_hold <= lane_byte;
      end
    end
  end

endmodule

// File: tb/tb_result_ram_writer.sv
// Randomized and directed stimulus for result_ram_writer, checked every cycle against a record-level model.
module tb_result_ram_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_value;
  logic [15:0] res_rest;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  rec_count;
  logic        full;
  logic        busy;

  always #5 clk = ~clk;

  result_ram_writer dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_value (res_value),
    .res_rest  (res_rest),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rec_count (rec_count),
    .full      (full),
    .busy      (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_wr   = 0;
  int cyc    = 0;

  // Reference model: phase 0 = waiting, 1..4 = byte k-1 of the record is on the bus.
  int   m_phase, m_ptr, m_cnt, last_addr, last_data;
  bit   m_full, m_acc;
  logic [7:0] m_rec [4];
  logic [7:0] m_mem [512];
  logic [7:0] d_mem [512];

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_cnt = 0; m_full = 0; m_acc = 0;
    last_addr = 0; last_data = 0;
  endtask

  task automatic model_edge();
    m_acc = 0;
    if (clear) begin
      m_phase = 0; m_ptr = 0; m_cnt = 0; m_full = 0;
    end else if (m_phase != 0) begin
      last_addr = m_ptr;
      last_data = m_rec[m_phase-1];
      m_mem[m_ptr] = m_rec[m_phase-1];
      m_ptr = (m_ptr + 1) % 512;
      if (m_phase == 4) begin
        m_phase = 0;
        m_cnt++;
        if (m_ptr == 0) m_full = 1;
      end else begin
        m_phase++;
      end
    end else if (res_valid && !m_full) begin
      m_rec[0] = res_value[7:0];
      m_rec[1] = res_value[15:8];
      m_rec[2] = res_rest[7:0];
      m_rec[3] = res_rest[15:8];
      m_phase  = 1;
      m_acc    = 1;
    end
  endtask

  task automatic check_outputs();
    bit e_wr;
    int e_addr, e_data;
    e_wr   = (m_phase != 0) && !clear;
    e_addr = last_addr;
    e_data = last_data;
    if (e_wr) begin
      e_addr = m_ptr;
      e_data = m_rec[m_phase-1];
    end
    check("res_ready", res_ready, (m_phase == 0) && !m_full && !clear);
    check("wr_en", wr_en, e_wr);
    check("wr_addr", wr_addr, e_addr);
    check("wr_data", wr_data, e_data);
    check("busy", busy, m_phase != 0);
    check("full", full, m_full);
    check("rec_count", rec_count, m_cnt);
    if (wr_en) begin
      d_mem[wr_addr] = wr_data;
      n_wr++;
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    res_valid = 1'b0;
    repeat (n) cycle();
  endtask

  // Leaves res_valid high so a following send is back-to-back.
  task automatic send(input logic [15:0] v, input logic [15:0] r);
    bit done;
    done = 0;
    res_valid = 1'b1;
    res_value = v;
    res_rest  = r;
    for (int k = 0; k < 200 && !done; k++) begin
      cycle();
      if (m_acc) done = 1;
    end
    if (!done) check("send_timeout", 1, 0);
  endtask

  task automatic pulse_clear();
    res_valid = 1'b0;
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  int t0, wr_before;

  initial begin
    reset = 1'b1; clear = 1'b0; res_valid = 1'b0; res_value = '0; res_rest = '0;
    model_reset();
    for (int a = 0; a < 512; a++) begin
      m_mem[a] = '0;
      d_mem[a] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_count", rec_count, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    reset = 1'b0;
    idle(2);

    // Single record
    send(16'h1234, 16'h0005);
    idle(4);
    check("single_a0", d_mem[0], 8'h34);
    check("single_a1", d_mem[1], 8'h12);
    check("single_a2", d_mem[2], 8'h05);
    check("single_a3", d_mem[3], 8'h00);
    check("single_cnt", rec_count, 1);
    check("single_ready", res_ready, 1);

    // Back-to-back from a fresh pointer
    pulse_clear();
    send(16'h00FF, 16'h0000);
    t0 = cyc;
    send(16'hABCD, 16'h0102);
    check("b2b_gap", cyc - t0, 5);
    idle(5);
    check("b2b_a4", d_mem[4], 8'hCD);
    check("b2b_a5", d_mem[5], 8'hAB);
    check("b2b_a6", d_mem[6], 8'h02);
    check("b2b_a7", d_mem[7], 8'h01);
    check("b2b_cnt", rec_count, 2);

    // Random traffic with occasional clears, some landing mid-record
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom), 16'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        res_valid = 1'b0;
        repeat ($urandom_range(0, 4)) cycle();
        pulse_clear();
      end else begin
        idle($urandom_range(0, 3));
      end
    end
    idle(5);

    // Clear during WB2 of record 3 (would write addr 10); valid in that cycle must be ignored
    pulse_clear();
    m_mem[10] = 8'h5A;
    d_mem[10] = 8'h5A;
    send(16'h1111, 16'h2222);
    send(16'h3333, 16'h4444);
    send(16'h5555, 16'h6677);
    res_valid = 1'b0;
    repeat (2) cycle();
    clear = 1'b1;
    res_valid = 1'b1;
    #1;
    check("clr_wr_en", wr_en, 0);
    check("clr_ready", res_ready, 0);
    cycle();
    clear = 1'b0;
    idle(1);
    check("clr_a10", d_mem[10], 8'h5A);
    check("clr_cnt", rec_count, 0);
    send(16'hC0DE, 16'h0042);
    idle(4);
    check("clr_rewrite_a0", d_mem[0], 8'hDE);
    check("clr_rewrite_a3", d_mem[3], 8'h00);

    // Asynchronous reset while WB1 is on the bus
    send(16'h9876, 16'h0001);
    res_valid = 1'b0;
    cycle();
    #2 reset = 1'b1;
    #1;
    check("arst_wr_en", wr_en, 0);
    check("arst_busy", busy, 0);
    check("arst_count", rec_count, 0);
    check("arst_addr", wr_addr, 0);
    check("arst_data", wr_data, 0);
    check("arst_full", full, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Fill all 128 slots, then keep valid high: nothing more may be written
    pulse_clear();
    for (int i = 0; i < 128; i++) send(16'($urandom), 16'($urandom));
    res_value = 16'hFFFF;
    res_rest  = 16'hFFFF;
    repeat (4) cycle();
    check("fill_full", full, 1);
    check("fill_ready", res_ready, 0);
    check("fill_cnt", rec_count, 128);
    check("fill_last_addr", wr_addr, 511);
    wr_before = n_wr;
    repeat (10) cycle();
    check("fill_no_wr", n_wr - wr_before, 0);

    // Clear out of FULL and start over at address 0
    pulse_clear();
    #1;
    check("fclr_full", full, 0);
    check("fclr_ready", res_ready, 1);
    send(16'hBEEF, 16'hF00D);
    idle(5);
    check("fclr_a0", d_mem[0], 8'hEF);
    check("fclr_a1", d_mem[1], 8'hBE);
    check("fclr_a2", d_mem[2], 8'h0D);
    check("fclr_a3", d_mem[3], 8'hF0);
    check("fclr_cnt", rec_count, 1);

    for (int a = 0; a < 512; a++) check($sformatf("mem[%0d]", a), d_mem[a], m_mem[a]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
